ci_initiator: RTL and testbench

- Hardware initiator for the multi-cycle custom-instruction handshake (dataa/datab/start -> done/result) used by our accelerator slaves, such as the frame-delay unit.
- Lets fabric logic (game-logic FSM, test sequencers) call a custom-instruction slave without the CPU.
- Accepts commands on a valid/ready port, drives one slave transaction at a time and returns result, measured latency and timeout status on a valid/ready response port.

---
 rtl/ci_pkg.sv | 16 +
 rtl/ci_timeout_counter.sv | 30 +++
 rtl/ci_initiator.sv | 117 +++++++++++
 tb/tb_ci_initiator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ci_pkg.sv
// Shared definitions for the custom-instruction initiator: FSM encoding,
// operand width and the default WAIT timeout.
package ci_pkg;

  localparam int CI_DATA_W          = 32;
  localparam int CI_TIMEOUT_DEFAULT = 1_000_000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    ABORT   = 3'd3,
    RESPOND = 3'd4
  } ci_state_e;

endpackage

// File: rtl/ci_timeout_counter.sv
// Latency/timeout counter: loads 1 on start, counts cycles without done and
// flags the terminal count; it parks at the terminal count so it never wraps.
module ci_timeout_counter #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= CNT_W'(1);
      end else if (inc && !tc) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ci_initiator.sv
// Fabric-side initiator for the multi-cycle custom-instruction handshake:
// one command in, one slave transaction, one response (result, latency, timeout) out.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CI_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CI_DATA_W-1:0] cmd_a,
  input  logic [CI_DATA_W-1:0] cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CI_DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]     rsp_cycles,
  output logic                 rsp_timeout,
  output logic [CI_DATA_W-1:0] ci_dataa,
  output logic [CI_DATA_W-1:0] ci_datab,
  output logic                 ci_clk_en,
  output logic                 ci_start,
  output logic                 ci_reset,
  input  logic [CI_DATA_W-1:0] ci_result,
  input  logic                 ci_done
);

  ci_state_e        state;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             cnt_load;
  logic             cnt_inc;

  assign ci_clk_en = en;
  assign cnt_load  = (state == ISSUE);
  assign cnt_inc   = (state == WAIT) && !ci_done;

  ci_timeout_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .count   (count),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
      ci_dataa    <= '0;
      ci_datab    <= '0;
      ci_start    <= 1'b0;
      ci_reset    <= 1'b1;
    end else if (en) begin
      // start and slave-reset are single-cycle pulses unless re-armed below
      ci_start <= 1'b0;
      ci_reset <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            ci_dataa  <= cmd_a;
            ci_datab  <= cmd_b;
            cmd_ready <= 1'b0;
            ci_start  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over a coincident terminal count
          if (ci_done) begin
            rsp_data    <= ci_result;
            rsp_cycles  <= count;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESPOND;
          end else if (tc) begin
            ci_reset <= 1'b1;
            state    <= ABORT;
          end
        end
        ABORT: begin
          rsp_data    <= '0;
          rsp_cycles  <= CNT_W'(TIMEOUT_CYCLES);
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ci_initiator.sv
// Scoreboard bench for ci_initiator driving a latency-programmable slave model.
module tb_ci_initiator;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset_n, en, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic        ci_clk_en, ci_start, ci_reset, ci_done;
  logic [31:0] cmd_a, cmd_b, rsp_data, rsp_cycles, ci_dataa, ci_datab, ci_result;

  logic s_done     = 1'b0;
  logic stray_done = 1'b0;
  int   lat        = 0;

  assign ci_done   = s_done | stray_done;
  assign ci_result = ci_dataa + ci_datab;

  always #5 clk = ~clk;

  ci_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_cycles  (rsp_cycles),
    .rsp_timeout (rsp_timeout),
    .ci_dataa    (ci_dataa),
    .ci_datab    (ci_datab),
    .ci_clk_en   (ci_clk_en),
    .ci_start    (ci_start),
    .ci_reset    (ci_reset),
    .ci_result   (ci_result),
    .ci_done     (ci_done)
  );

  // Slave model: done pulses lat clock-enabled cycles after it sees start; lat=0 never answers.
  initial begin
    logic st, ce, rs;
    int   rem;
    rem = 0;
    forever begin
      @(posedge clk);
      st = ci_start;
      ce = ci_clk_en;
      rs = ci_reset;
      #1;
      if (rs) begin
        rem    = 0;
        s_done = 1'b0;
      end else if (ce) begin
        s_done = 1'b0;
        if (st) begin
          rem = lat;
        end else if (rem > 0) begin
          rem = rem - 1;
          if (rem == 0) s_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cycles;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, nstart = 0, start_cyc = 0, nreset_hi = 0, reset_cyc = 0, rsp_hs_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (ci_start) begin
        nstart++;
        start_cyc = cyc;
      end
      if (ci_reset) begin
        if (nreset_hi == 0) reset_cyc = cyc;
        nreset_hi++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_hs_cyc = cyc;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%0h with no pending command", rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_cycles", rsp_cycles, e.cycles);
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push,
                      input logic [31:0] ed, input logic [31:0] ec, input logic et);
    bit acc;
    if (push) sb.push_back(exp_t'{data: ed, cycles: ec, to: et});
    @(posedge clk); #1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    acc       = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !rsp_valid) break;
      @(negedge clk);
    end
    check("rsp_drain", sb.size(), 32'd0);
  endtask

  initial begin
    bit ok, cr_low;
    int hs1;
    reset_n = 1'b0; en = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_a = '0; cmd_b = '0;
    fork
      monitor();
    join_none

    // Reset values
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_cycles", rsp_cycles, 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_ci_dataa", ci_dataa, 32'd0);
    check("rst_ci_start", 32'(ci_start), 32'd0);
    check("rst_ci_reset", 32'(ci_reset), 32'd1);
    @(posedge clk); #3 reset_n = 1'b1;
    #1 check("ci_reset_after_release", 32'(ci_reset), 32'd1);
    @(posedge clk); #1;
    check("ci_reset_first_edge", 32'(ci_reset), 32'd0);
    check("cmd_ready_first_edge", 32'(cmd_ready), 32'd1);

    // Latency-5 slave: 0x12 + 0x34 = 0x46, counter 6 at done
    lat = 5; nstart = 0;
    send(32'h12, 32'h34, 1'b1, 32'h46, 32'd6, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (ci_dataa !== 32'h12 || ci_datab !== 32'h34) ok = 1'b0;
    end
    check("operands_held", 32'(ok), 32'd1);
    check("single_start", nstart, 32'd1);
    wait_idle();

    // Slave never answers: abort with a one-cycle ci_reset 21 cycles after start
    lat = 0; nstart = 0; nreset_hi = 0;
    send(32'hAA, 32'h55, 1'b1, 32'd0, 32'd20, 1'b1);
    wait_idle();
    check("abort_reset_len", nreset_hi, 32'd1);
    check("abort_reset_delay", reset_cyc - start_cyc, 32'd21);
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_no_rsp", 32'(rsp_valid), 32'd0);
    check("late_done_idle", 32'(cmd_ready), 32'd1);

    // Done coincides with terminal count: done wins
    lat = 19; nreset_hi = 0;
    send(32'h100, 32'h23, 1'b1, 32'h123, 32'd20, 1'b0);
    wait_idle();
    check("coincide_no_reset", nreset_hi, 32'd0);

    // Back-to-back with the response held off for 10 cycles
    rsp_ready = 1'b0; lat = 2; nstart = 0;
    send(32'h1, 32'h2, 1'b1, 32'h3, 32'd3, 1'b0);
    cmd_a = 32'h10; cmd_b = 32'h20; cmd_valid = 1'b1;
    sb.push_back(exp_t'{data: 32'h30, cycles: 32'd3, to: 1'b0});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    ok = 1'b1; cr_low = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'h3 || rsp_cycles !== 32'd3 || rsp_timeout !== 1'b0) ok = 1'b0;
      if (cmd_ready !== 1'b0) cr_low = 1'b0;
    end
    check("rsp_stable", 32'(ok), 32'd1);
    check("cmd_ready_low", 32'(cr_low), 32'd1);
    check("no_second_start", nstart, 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 hs1 = rsp_hs_cyc;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("second_accept", 32'(ok), 32'd1);
    wait_idle();
    check("second_start_gap", start_cyc - hs1, 32'd2);
    check("two_starts", nstart, 32'd2);

    // en low for 7 cycles mid-WAIT
    lat = 5;
    send(32'h7, 32'h8, 1'b1, 32'hF, 32'd6, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 en = 1'b0;
    ok = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (ci_clk_en !== 1'b0 || rsp_valid !== 1'b0 || ci_dataa !== 32'h7) ok = 1'b0;
    end
    @(posedge clk); #1 en = 1'b1;
    check("en_low_frozen", 32'(ok), 32'd1);
    wait_idle();

    // Asynchronous reset mid-WAIT: response lost, slave reset, stray done ignored
    lat = 5;
    send(32'h9, 32'h9, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("mid_rst_ci_reset", 32'(ci_reset), 32'd1);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_ci_dataa", ci_dataa, 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(posedge clk); #3 reset_n = 1'b1;
    #1 check("mid_rst_held", 32'(ci_reset), 32'd1);
    @(posedge clk); #1;
    check("mid_rst_release", 32'(ci_reset), 32'd0);
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_no_rsp", 32'(rsp_valid), 32'd0);
    check("stray_idle", 32'(cmd_ready), 32'd1);

    // Recovery transaction
    lat = 3;
    send(32'h5, 32'h6, 1'b1, 32'hB, 32'd4, 1'b0);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
